// File: rtl/projectile_motion.sv
// projectile_motion: fixed-point projectile kinematics engine.
// Latches a launch velocity, integrates position once per FrameTick under constant
// gravity, and ends each flight with a single-cycle Hit or Miss pulse.
module projectile_motion #(
    parameter int FRAC     = 4,    // fractional bits of position/velocity
    parameter int VSCALE   = 3,    // launch velocity = v << VSCALE sub-px/frame
    parameter int GRAVITY  = 4,    // sub-px/frame^2 added to Y velocity per tick
    parameter int START_X  = 200,  // launch point, pixels
    parameter int START_Y  = 460,
    parameter int X_MIN    = 160,  // play-field limits, pixels
    parameter int X_MAX    = 775,
    parameter int Y_MIN    = 50,
    parameter int Y_MAX    = 475,
    parameter int TGT_X_LO = 650,  // target zone, pixels, inclusive
    parameter int TGT_X_HI = 675,
    parameter int TGT_Y_LO = 470,
    parameter int TGT_Y_HI = 475
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Launch,
    input  logic       FrameTick,
    input  logic [3:0] vX,
    input  logic [3:0] vY,
    output logic [9:0] projectileCenterX,
    output logic [9:0] projectileCenterY,
    output logic       Busy,
    output logic       Hit,
    output logic       Miss
);

    typedef enum logic [1:0] {
        IDLE,
        FLIGHT,
        LANDED
    } state_t;

    // Start point and limits in the same signed 16-bit domain as the position.
    localparam logic signed [15:0] POS_X_START = 16'(START_X << FRAC);
    localparam logic signed [15:0] POS_Y_START = 16'(START_Y << FRAC);
    localparam logic signed [15:0] LIM_X_MIN   = 16'(X_MIN);
    localparam logic signed [15:0] LIM_X_MAX   = 16'(X_MAX);
    localparam logic signed [15:0] LIM_Y_MIN   = 16'(Y_MIN);
    localparam logic signed [15:0] LIM_Y_MAX   = 16'(Y_MAX);
    localparam logic signed [15:0] TGT_XL      = 16'(TGT_X_LO);
    localparam logic signed [15:0] TGT_XH      = 16'(TGT_X_HI);
    localparam logic signed [15:0] TGT_YL      = 16'(TGT_Y_LO);
    localparam logic signed [15:0] TGT_YH      = 16'(TGT_Y_HI);

    // Y velocity saturates at +2047 so a long fall can never wrap to an upward speed.
    localparam logic signed [11:0] VEL_Y_MAX = 12'sd2047;
    localparam logic signed [11:0] VEL_Y_SAT = 12'(2047 - GRAVITY);
    localparam logic signed [11:0] GRAV_INC  = 12'(GRAVITY);

    localparam logic [9:0] CENTER_X_START = 10'(START_X);
    localparam logic [9:0] CENTER_Y_START = 10'(START_Y);

    state_t             state_q, state_d;
    logic signed [15:0] pos_x_q, pos_x_d;
    logic signed [15:0] pos_y_q, pos_y_d;
    logic        [7:0]  vel_x_q, vel_x_d;
    logic signed [11:0] vel_y_q, vel_y_d;
    logic               busy_q, busy_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic        [9:0]  center_x_q, center_x_d;
    logic        [9:0]  center_y_q, center_y_d;

    // Integer pixel position: arithmetic shift keeps negative Y negative.
    logic signed [15:0] int_x_q, int_y_q;
    logic signed [15:0] int_x_d, int_y_d;
    logic               in_target, out_field;

    assign int_x_q = pos_x_q >>> FRAC;
    assign int_y_q = pos_y_q >>> FRAC;
    assign int_x_d = pos_x_d >>> FRAC;
    assign int_y_d = pos_y_d >>> FRAC;

    // Termination tests on the registered position; the target test wins at Y = 475.
    assign in_target = (int_x_q >= TGT_XL) && (int_x_q <= TGT_XH) &&
                       (int_y_q >= TGT_YL) && (int_y_q <= TGT_YH);
    assign out_field = (int_x_q >= LIM_X_MAX) || (int_x_q <= LIM_X_MIN) ||
                       (int_y_q >= LIM_Y_MAX) || (int_y_q <= LIM_Y_MIN);

    // Next-state logic: launch capture, per-frame integration and flight termination.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        vel_x_d = vel_x_q;
        vel_y_d = vel_y_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A FrameTick arriving with Launch is dropped: the flight starts at rest.
                if (Launch) begin
                    state_d = FLIGHT;
                    pos_x_d = POS_X_START;
                    pos_y_d = POS_Y_START;
                    vel_x_d = 8'(vX) << VSCALE;
                    vel_y_d = -(12'(vY) << VSCALE);
                end
            end
            FLIGHT: begin
                // Once the current position terminates the flight it is frozen as final.
                if (in_target) begin
                    state_d = LANDED;
                    hit_d   = 1'b1;
                end else if (out_field) begin
                    state_d = LANDED;
                    miss_d  = 1'b1;
                end else if (FrameTick) begin
                    // Position advances with the old Y velocity; gravity applies afterwards.
                    pos_x_d = pos_x_q + {8'b0, vel_x_q};
                    pos_y_d = pos_y_q + {{4{vel_y_q[11]}}, vel_y_q};
                    vel_y_d = (vel_y_q > VEL_Y_SAT) ? VEL_Y_MAX : vel_y_q + GRAV_INC;
                end
            end
            LANDED: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d     = (state_d == FLIGHT);
        center_x_d = (int_x_d < 0) ? 10'd0 : int_x_d[9:0];
        center_y_d = (int_y_d < 0) ? 10'd0 : int_y_d[9:0];
    end

    // State and output registers with synchronous reset; reset aborts any flight silently.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (Reset) begin
            state_q    <= IDLE;
            pos_x_q    <= POS_X_START;
            pos_y_q    <= POS_Y_START;
            vel_x_q    <= '0;
            vel_y_q    <= '0;
            busy_q     <= 1'b0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            center_x_q <= CENTER_X_START;
            center_y_q <= CENTER_Y_START;
        end else begin
            state_q    <= state_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            vel_x_q    <= vel_x_d;
            vel_y_q    <= vel_y_d;
            busy_q     <= busy_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            center_x_q <= center_x_d;
            center_y_q <= center_y_d;
        end
    end

    assign projectileCenterX = center_x_q;
    assign projectileCenterY = center_y_q;
    assign Busy              = busy_q;
    assign Hit               = hit_q;
    assign Miss              = miss_q;

endmodule

// File: tb/tb_projectile_motion.sv
// Testbench for projectile_motion: three instances with different launch points share
// one stimulus bus; directed vectors, hand sequences and a randomized sweep are all
// checked against constants or a closed-form kinematics model.
module tb_projectile_motion;

    localparam int FRAC    = 4;
    localparam int VSCALE  = 3;
    localparam int GRAVITY = 4;
    localparam int NDUT    = 3;

    logic             clk = 1'b0;
    logic             Reset, Launch, FrameTick;
    logic [3:0]       vX, vY;
    logic [2:0][9:0]  cx, cy;
    logic [2:0]       busy, hit, miss;

    int n_checks = 0;
    int n_fail   = 0;

    // Launch points of the three instances, pixels.
    int sx_tab[NDUT] = '{200, 660, 200};
    int sy_tab[NDUT] = '{460, 465, 60};

    always #5 clk = ~clk;

    projectile_motion u_dut0 (
        .clk(clk), .Reset(Reset), .Launch(Launch), .FrameTick(FrameTick),
        .vX(vX), .vY(vY),
        .projectileCenterX(cx[0]), .projectileCenterY(cy[0]),
        .Busy(busy[0]), .Hit(hit[0]), .Miss(miss[0])
    );

    projectile_motion #(.START_X(660), .START_Y(465)) u_dut1 (
        .clk(clk), .Reset(Reset), .Launch(Launch), .FrameTick(FrameTick),
        .vX(vX), .vY(vY),
        .projectileCenterX(cx[1]), .projectileCenterY(cy[1]),
        .Busy(busy[1]), .Hit(hit[1]), .Miss(miss[1])
    );

    projectile_motion #(.START_Y(60)) u_dut2 (
        .clk(clk), .Reset(Reset), .Launch(Launch), .FrameTick(FrameTick),
        .vX(vX), .vY(vY),
        .projectileCenterX(cx[2]), .projectileCenterY(cy[2]),
        .Busy(busy[2]), .Hit(hit[2]), .Miss(miss[2])
    );

    typedef struct {
        int dut;
        int vx;
        int vy;
        int ticks;   // FrameTick count whose update ends the flight
        bit is_hit;
        int x;
        int y;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // One clock cycle: inputs applied at the falling edge, outputs settled 1 unit after rise.
    task automatic step(input logic launch, input logic tick, input logic rst);
        @(negedge clk);
        Launch    = launch;
        FrameTick = tick;
        Reset     = rst;
        @(posedge clk);
        #1;
        Launch    = 1'b0;
        FrameTick = 1'b0;
        Reset     = 1'b0;
    endtask

    // Closed-form position after n ticks: x = x0 + n*vx', y = y0 - n*vy' + g*n(n-1)/2.
    function automatic void model_at(input int d, input int vx, input int vy, input int n,
                                     output int x, output int y);
        int px, py;
        px = sx_tab[d] * (1 << FRAC) + n * (vx << VSCALE);
        py = sy_tab[d] * (1 << FRAC) - n * (vy << VSCALE) + GRAVITY * n * (n - 1) / 2;
        x  = px >>> FRAC;
        y  = py >>> FRAC;
    endfunction

    function automatic int clamp0(input int v);
        return (v < 0) ? 0 : v;
    endfunction

    // First tick count at which the pixel position lands in the target or leaves the field.
    function automatic void model_end(input int d, input int vx, input int vy,
                                      output int n_end, output bit is_hit);
        int  x, y;
        bit  tgt, out;
        n_end  = -1;
        is_hit = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            model_at(d, vx, vy, n, x, y);
            tgt = (x >= 650) && (x <= 675) && (y >= 470) && (y <= 475);
            out = (x >= 775) || (x <= 160) || (y >= 475) || (y <= 50);
            if (tgt || out) begin
                n_end  = n;
                is_hit = tgt;
                break;
            end
        end
    endfunction

    task automatic check_idle_state(input string tag);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("%s_d%0d_x", tag, d), 32'(cx[d]), sx_tab[d]);
            check($sformatf("%s_d%0d_y", tag, d), 32'(cy[d]), sy_tab[d]);
            check($sformatf("%s_d%0d_busy", tag, d), 32'(busy[d]), 0);
            check($sformatf("%s_d%0d_hit", tag, d), 32'(hit[d]), 0);
            check($sformatf("%s_d%0d_miss", tag, d), 32'(miss[d]), 0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[6];
        int   n, pulses, x, y;
        bit   found;
        int   exp_n[NDUT];
        bit   exp_hit[NDUT];
        bit   landed[NDUT];
        int   pulse_cnt[NDUT];
        bit   all_landed;

        Reset = 1'b0; Launch = 1'b0; FrameTick = 1'b0; vX = '0; vY = '0;

        vecs[0] = '{dut: 0, vx: 4,  vy: 0,  ticks: 12, is_hit: 1'b0, x: 224, y: 476};
        vecs[1] = '{dut: 0, vx: 0,  vy: 0,  ticks: 12, is_hit: 1'b0, x: 200, y: 476};
        vecs[2] = '{dut: 1, vx: 0,  vy: 0,  ticks: 7,  is_hit: 1'b1, x: 660, y: 470};
        vecs[3] = '{dut: 1, vx: 4,  vy: 0,  ticks: 7,  is_hit: 1'b1, x: 674, y: 470};
        vecs[4] = '{dut: 2, vx: 0,  vy: 15, ticks: 2,  is_hit: 1'b0, x: 200, y: 45};
        vecs[5] = '{dut: 2, vx: 15, vy: 0,  ticks: 59, is_hit: 1'b0, x: 642, y: 487};

        // Reset state
        step(1'b0, 1'b0, 1'b1);
        check_idle_state("reset");

        // Directed flights from the vector table
        for (int i = 0; i < 6; i++) begin
            int d;
            d = vecs[i].dut;
            step(1'b0, 1'b0, 1'b1);
            vX = 4'(vecs[i].vx);
            vY = 4'(vecs[i].vy);
            step(1'b1, 1'b0, 1'b0);
            check($sformatf("vec%0d_busy_launch", i), 32'(busy[d]), 1);
            n = 0;
            found = 1'b0;
            while (!found && n < 200) begin
                step(1'b0, 1'b1, 1'b0);
                n++;
                step(1'b0, 1'b0, 1'b0);
                if (hit[d] || miss[d]) found = 1'b1;
            end
            check($sformatf("vec%0d_ended", i), 32'(found), 1);
            check($sformatf("vec%0d_ticks", i), n, vecs[i].ticks);
            check($sformatf("vec%0d_hit", i), 32'(hit[d]), 32'(vecs[i].is_hit));
            check($sformatf("vec%0d_miss", i), 32'(miss[d]), 32'(!vecs[i].is_hit));
            check($sformatf("vec%0d_x", i), 32'(cx[d]), vecs[i].x);
            check($sformatf("vec%0d_y", i), 32'(cy[d]), vecs[i].y);
            check($sformatf("vec%0d_busy_end", i), 32'(busy[d]), 0);
            step(1'b0, 1'b1, 1'b0);
            check($sformatf("vec%0d_pulse_len", i), 32'(hit[d] | miss[d]), 0);
            check($sformatf("vec%0d_x_hold", i), 32'(cx[d]), vecs[i].x);
            check($sformatf("vec%0d_y_hold", i), 32'(cy[d]), vecs[i].y);
        end

        // Steep upward launch from a low start: Y steps 52 then 45, Miss on the next cycle
        step(1'b0, 1'b0, 1'b1);
        vX = 4'd0; vY = 4'd15;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("up_tick1_y", 32'(cy[2]), 52);
        step(1'b0, 1'b0, 1'b0);
        check("up_tick1_busy", 32'(busy[2]), 1);
        check("up_tick1_miss", 32'(miss[2]), 0);
        step(1'b0, 1'b1, 1'b0);
        check("up_tick2_y", 32'(cy[2]), 45);
        step(1'b0, 1'b0, 1'b0);
        check("up_miss", 32'(miss[2]), 1);
        check("up_hit", 32'(hit[2]), 0);
        check("up_busy_low", 32'(busy[2]), 0);
        step(1'b0, 1'b0, 1'b0);
        check("up_miss_drop", 32'(miss[2]), 0);

        // Launch with a simultaneous FrameTick, then a second Launch mid-flight
        step(1'b0, 1'b0, 1'b1);
        vX = 4'd4; vY = 4'd0;
        step(1'b1, 1'b1, 1'b0);
        check("lt_x_start", 32'(cx[0]), 200);
        check("lt_y_start", 32'(cy[0]), 460);
        check("lt_busy", 32'(busy[0]), 1);
        step(1'b0, 1'b1, 1'b0);
        check("lt_tick1_x", 32'(cx[0]), 202);
        vX = 4'd15; vY = 4'd15;
        step(1'b1, 1'b0, 1'b0);
        check("relaunch_busy", 32'(busy[0]), 1);
        step(1'b0, 1'b1, 1'b0);
        check("relaunch_tick2_x", 32'(cx[0]), 204);
        check("relaunch_tick2_y", 32'(cy[0]), 460);

        // Reset at the fifth tick of a flight: back to idle without any pulse
        step(1'b0, 1'b0, 1'b1);
        vX = 4'd4; vY = 4'd0;
        step(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b1, 1'b1);
        check_idle_state("abort");
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0);
            if (hit[0] || miss[0]) pulses++;
        end
        check("abort_no_pulse", pulses, 0);
        check("abort_x_hold", 32'(cx[0]), 200);
        check("abort_y_hold", 32'(cy[0]), 460);
        check("abort_busy", 32'(busy[0]), 0);

        // Randomized sweep against the closed-form model, back to back without reset
        for (int l = 0; l < 40; l++) begin
            vX = 4'($urandom_range(0, 15));
            vY = 4'($urandom_range(0, 15));
            for (int d = 0; d < NDUT; d++) begin
                model_end(d, int'(vX), int'(vY), exp_n[d], exp_hit[d]);
                landed[d]    = 1'b0;
                pulse_cnt[d] = 0;
            end
            step(1'b1, 1'b0, 1'b0);
            for (int d = 0; d < NDUT; d++)
                check($sformatf("rnd%0d_d%0d_busy", l, d), 32'(busy[d]), 1);
            n = 0;
            all_landed = 1'b0;
            while (!all_landed && n < 200) begin
                step(1'b0, 1'b1, 1'b0);
                n++;
                for (int d = 0; d < NDUT; d++) begin
                    if (!landed[d]) begin
                        model_at(d, int'(vX), int'(vY), n, x, y);
                        check($sformatf("rnd%0d_d%0d_n%0d_x", l, d, n), 32'(cx[d]), clamp0(x));
                        check($sformatf("rnd%0d_d%0d_n%0d_y", l, d, n), 32'(cy[d]), clamp0(y));
                    end
                end
                repeat ($urandom_range(1, 3)) begin
                    step(1'b0, 1'b0, 1'b0);
                    for (int d = 0; d < NDUT; d++) begin
                        if (hit[d] || miss[d]) begin
                            pulse_cnt[d]++;
                            if (!landed[d]) begin
                                landed[d] = 1'b1;
                                check($sformatf("rnd%0d_d%0d_ticks", l, d), n, exp_n[d]);
                                check($sformatf("rnd%0d_d%0d_hit", l, d), 32'(hit[d]), 32'(exp_hit[d]));
                                check($sformatf("rnd%0d_d%0d_miss", l, d), 32'(miss[d]), 32'(!exp_hit[d]));
                                check($sformatf("rnd%0d_d%0d_busy_end", l, d), 32'(busy[d]), 0);
                            end
                        end
                    end
                end
                all_landed = landed[0] && landed[1] && landed[2];
            end
            repeat (2) begin
                step(1'b0, 1'b0, 1'b0);
                for (int d = 0; d < NDUT; d++)
                    if (hit[d] || miss[d]) pulse_cnt[d]++;
            end
            for (int d = 0; d < NDUT; d++) begin
                check($sformatf("rnd%0d_d%0d_ended", l, d), 32'(landed[d]), 1);
                check($sformatf("rnd%0d_d%0d_one_pulse", l, d), pulse_cnt[d], 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
